instr_mem_responder: RTL and testbench

Instruction-memory responder for the single-cycle/multi-cycle CPU datapath; serves fetch requests issued by the program-counter side.
- Accepts a word address over a valid/ready request channel.
- Returns the 32-bit instruction over a valid/ready response channel after a programmable wait-state latency.
- Provides a load port so the testbench or boot logic can write program words.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/instr_mem_responder_if.sv | 25 ++
 rtl/imem_array.sv | 31 +++
 rtl/instr_mem_responder.sv | 133 +++++++++++++
 tb/tb_instr_mem_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory responder.
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - instruction width, fault-response data word, wait-counter width
//   - addr_fault(): misalignment / range check used by the fault-trap build
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          INSTR_W     = 32;
  localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;
  localparam int          CNT_W       = 4;

  // A byte address is bad if it is not word aligned or lies past the last word.
  function automatic logic addr_fault(input logic [31:0] addr, input int depth_words);
    logic [31:0] limit;
    limit      = 32'(depth_words) << 2;
    addr_fault = (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: fetch request / response channel between the
// program-counter side (master) and the instruction memory (slave).
//   req_valid/req_ready/req_addr         : fetch request handshake, byte address
//   rsp_valid/rsp_ready/rsp_instr/fault  : response handshake, instruction, fault flag
interface instr_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );

endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x 32-bit instruction storage.
//   CLK   : write clock
//   we    : write strobe, waddr/wdata written on the rising edge
//   raddr : combinational read address, rdata is the stored word
// Contents are never reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH_WORDS];

  // Synchronous program-load write.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction-memory responder for the CPU fetch path.
// Accepts a byte address on the request channel and returns the stored word
// WAIT_CYCLES+1 clock edges after acceptance on the response channel.
//   CLK, Reset          : clock, synchronous active-high reset
//   bus (slave modport) : request/response handshake channel
//   load_en/addr/data   : program-load write port, honoured only in IDLE
//   busy                : high whenever the FSM is not IDLE
// Build option: define IMEM_FAULT_TRAP_EN to flag misaligned/out-of-range
// requests (rsp_fault=1, rsp_instr=0) and drop such loads. Without it,
// address bits [1:0] are ignored and word indices wrap modulo DEPTH_WORDS.
module instr_mem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    Reset,
  instr_mem_responder_if.slave    bus,
  input  logic                    load_en,
  input  logic [31:0]             load_addr,
  input  logic [INSTR_W-1:0]      load_data,
  output logic                    busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [AW-1:0]      idx_q;
  logic               fault_q;
  logic               rsp_valid_q;
  logic [INSTR_W-1:0] rsp_instr_q;
  logic               rsp_fault_q;

  logic               accept;
  logic               req_ready_c;
  logic               req_fault;
  logic               load_ok;
  logic               we;
  logic [INSTR_W-1:0] rdata;

`ifdef IMEM_FAULT_TRAP_EN
  assign req_fault = addr_fault(bus.req_addr, DEPTH_WORDS);
  assign load_ok   = ~addr_fault(load_addr, DEPTH_WORDS);
`else
  // Address bits outside the word index are don't-care when wrapping.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0],
                              load_addr[31:AW+2], load_addr[1:0]};
  assign req_fault = 1'b0;
  assign load_ok   = 1'b1;
`endif

  // A load in IDLE blocks request acceptance for that cycle.
  always_comb begin
    req_ready_c = 1'b0;
    if (state == IDLE) begin
      req_ready_c = ~load_en;
    end else begin
      req_ready_c = 1'b0;
    end
  end

  assign accept        = bus.req_valid & req_ready_c;
  assign we            = (state == IDLE) & load_en & load_ok;
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_instr = rsp_instr_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign busy          = (state != IDLE);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (we),
    .waddr (load_addr[AW+1:2]),
    .wdata (load_data),
    .raddr (idx_q),
    .rdata (rdata)
  );

  // Fetch FSM. WAIT is entered on every acceptance and left once the counter
  // has drained to zero, so RESP is entered exactly WAIT_CYCLES+1 edges after
  // the accepting edge (WAIT_CYCLES=0 spends a single cycle in WAIT).
  // Response data is captured on the edge entering RESP and held until the
  // handshake; no load can reach the array in between, since loads need IDLE.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= {CNT_W{1'b0}};
      idx_q       <= {AW{1'b0}};
      fault_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= FAULT_INSTR;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= bus.req_addr[AW+1:2];
            fault_q <= req_fault;
            cnt     <= CNT_W'(WAIT_CYCLES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == {CNT_W{1'b0}}) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_instr_q <= fault_q ? FAULT_INSTR : rdata;
            rsp_fault_q <= fault_q;
          end else begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed testbench for instr_mem_responder: one instance with
// WAIT_CYCLES=2 (dut_a) and one with WAIT_CYCLES=0 (dut_b), DEPTH_WORDS=256.
module tb_instr_mem_responder;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  instr_mem_responder_if ifa ();
  instr_mem_responder_if ifb ();

  logic        load_en_a, load_en_b;
  logic [31:0] load_addr_a, load_addr_b;
  logic [31:0] load_data_a, load_data_b;
  logic        busy_a, busy_b;

  instr_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .CLK(CLK), .Reset(Reset), .bus(ifa.slave),
    .load_en(load_en_a), .load_addr(load_addr_a), .load_data(load_data_a),
    .busy(busy_a)
  );

  instr_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .CLK(CLK), .Reset(Reset), .bus(ifb.slave),
    .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b),
    .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_a(input logic [31:0] addr, input logic [31:0] data);
    load_en_a   = 1'b1;
    load_addr_a = addr;
    load_data_a = data;
    step();
    load_en_a   = 1'b0;
  endtask

  // Full fetch on dut_a: acceptance, 3-edge latency, optional backpressure
  // hold, then handshake and return to IDLE.
  task automatic fetch_a(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_instr, input logic exp_fault,
                         input int hold);
    ifa.req_valid = 1'b1;
    ifa.req_addr  = addr;
    #1;
    check({tag, " req_ready"}, ifa.req_ready, 32'd1);
    step();
    ifa.req_valid = 1'b0;
    check({tag, " busy_after_acc"}, busy_a, 32'd1);
    check({tag, " valid_t0"}, ifa.rsp_valid, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, " valid_lat"}, ifa.rsp_valid, (i == 3) ? 32'd1 : 32'd0);
    end
    check({tag, " instr"}, ifa.rsp_instr, exp_instr);
    check({tag, " fault"}, ifa.rsp_fault, 32'(exp_fault));
    for (int k = 0; k < hold; k++) begin
      ifa.req_valid = 1'b1;
      ifa.req_addr  = 32'h0000_0010;
      step();
      check({tag, " hold_valid"}, ifa.rsp_valid, 32'd1);
      check({tag, " hold_instr"}, ifa.rsp_instr, exp_instr);
      check({tag, " hold_fault"}, ifa.rsp_fault, 32'(exp_fault));
      check({tag, " hold_ready"}, ifa.req_ready, 32'd0);
      check({tag, " hold_busy"}, busy_a, 32'd1);
    end
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    step();
    ifa.rsp_ready = 1'b0;
    check({tag, " valid_after_hs"}, ifa.rsp_valid, 32'd0);
    check({tag, " busy_after_hs"}, busy_a, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    ifa.req_valid = 1'b0; ifa.req_addr = 32'h0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_addr = 32'h0; ifb.rsp_ready = 1'b0;
    load_en_a = 1'b0; load_addr_a = 32'h0; load_data_a = 32'h0;
    load_en_b = 1'b0; load_addr_b = 32'h0; load_data_b = 32'h0;
    step();
    step();
    Reset = 1'b0;

    // Reset state
    check("rst rsp_valid_a", ifa.rsp_valid, 32'd0);
    check("rst rsp_instr_a", ifa.rsp_instr, 32'h0);
    check("rst rsp_fault_a", ifa.rsp_fault, 32'd0);
    check("rst busy_a", busy_a, 32'd0);
    check("rst req_ready_a", ifa.req_ready, 32'd1);
    check("rst rsp_valid_b", ifb.rsp_valid, 32'd0);

    // Load then fetch with WAIT_CYCLES=2, followed by backpressure
    load_en_a = 1'b1; load_addr_a = 32'h4; load_data_a = 32'h8C01_0004;
    #1;
    check("load req_ready", ifa.req_ready, 32'd0);
    step();
    load_en_a = 1'b0;
    fetch_a("t1", 32'h4, 32'h8C01_0004, 1'b0, 0);
    fetch_a("bp", 32'h4, 32'h8C01_0004, 1'b0, 5);

    // Load and request in the same IDLE cycle: load wins
    load_en_a = 1'b1; load_addr_a = 32'h8; load_data_a = 32'hAC03_0008;
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h8;
    #1;
    check("same req_ready", ifa.req_ready, 32'd0);
    step();
    load_en_a = 1'b0;
    ifa.req_valid = 1'b0;
    check("same not_accepted", busy_a, 32'd0);
    fetch_a("t6", 32'h8, 32'hAC03_0008, 1'b0, 0);

`ifdef IMEM_FAULT_TRAP_EN
    fetch_a("mis", 32'h6, 32'h0, 1'b1, 0);
    fetch_a("oor", 32'h400, 32'h0, 1'b1, 0);
    load_a(32'hA, 32'hDEAD_BEEF);
    load_a(32'h408, 32'hDEAD_BEEF);
    fetch_a("drop", 32'h8, 32'hAC03_0008, 1'b0, 0);
`else
    fetch_a("wrap", 32'h404, 32'h8C01_0004, 1'b0, 0);
    fetch_a("low", 32'h6, 32'h8C01_0004, 1'b0, 0);
    load_a(32'h40E, 32'h1122_3344);
    fetch_a("ldwrap", 32'hC, 32'h1122_3344, 1'b0, 0);
`endif

    // Reset during WAIT discards the pending response
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h4;
    step();
    ifa.req_valid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rstw rsp_valid", ifa.rsp_valid, 32'd0);
    check("rstw busy", busy_a, 32'd0);
    check("rstw req_ready", ifa.req_ready, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rstw no_rsp", ifa.rsp_valid, 32'd0);
    end

    // Reset together with req_valid: nothing accepted
    Reset = 1'b1;
    ifa.req_valid = 1'b1; ifa.req_addr = 32'h4;
    step();
    Reset = 1'b0;
    ifa.req_valid = 1'b0;
    check("rstreq busy", busy_a, 32'd0);
    step();
    check("rstreq still_idle", busy_a, 32'd0);

    // Memory survives reset
    fetch_a("keep", 32'h4, 32'h8C01_0004, 1'b0, 0);

    // WAIT_CYCLES=0 instance
    load_en_b = 1'b1; load_addr_b = 32'h0; load_data_b = 32'h2002_0005;
    step();
    load_en_b = 1'b0;
    ifb.req_valid = 1'b1; ifb.req_addr = 32'h0;
    #1;
    check("w0 req_ready", ifb.req_ready, 32'd1);
    step();
    ifb.req_valid = 1'b0;
    check("w0 valid_t0", ifb.rsp_valid, 32'd0);
    step();
    check("w0 valid_t1", ifb.rsp_valid, 32'd1);
    check("w0 instr", ifb.rsp_instr, 32'h2002_0005);
    check("w0 fault", ifb.rsp_fault, 32'd0);
    ifb.req_valid = 1'b1;
    #1;
    check("w0 ready_in_resp", ifb.req_ready, 32'd0);
    ifb.req_valid = 1'b0;
    ifb.rsp_ready = 1'b1;
    step();
    ifb.rsp_ready = 1'b0;
    check("w0 valid_after_hs", ifb.rsp_valid, 32'd0);
    check("w0 busy_after_hs", busy_b, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
